// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART receive frame controller:
//   - state_e    : frame controller FSM state encoding (3 bits)
//   - err_code_e : error codes reported on err_code
//   - DEFAULT_SYNC_BYTE / DEFAULT_TIMEOUT_CNT : parameter defaults
//   - frame_chk  : 8-bit XOR checksum over the three payload bytes
// -----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        S_SYNC  = 3'd0,
        S_ADDR  = 3'd1,
        S_DH    = 3'd2,
        S_DL    = 3'd3,
        S_CHK   = 3'd4,
        S_WRITE = 3'd5
    } state_e;

    typedef enum logic [1:0] {
        ERR_NONE = 2'b00,
        ERR_CHK  = 2'b01,
        ERR_TMO  = 2'b10,
        ERR_OVR  = 2'b11
    } err_code_e;

    localparam logic [7:0]  DEFAULT_SYNC_BYTE   = 8'hAA;
    localparam logic [31:0] DEFAULT_TIMEOUT_CNT = 32'd50_000;

    function automatic logic [7:0] frame_chk(input logic [7:0] addr,
                                             input logic [7:0] data_h,
                                             input logic [7:0] data_l);
        return addr ^ data_h ^ data_l;
    endfunction

endpackage

// File: rtl/uart_rx_frame_ctrl_if.sv
// -----------------------------------------------------------------------------
// uart_rx_frame_ctrl_if
// Register-bank write bus between the frame controller and the register bank.
//   reg_wr_en    : write request, held until accepted
//   reg_addr     : write address, stable while reg_wr_en=1
//   reg_wr_data  : write data {DATA_H, DATA_L}, stable while reg_wr_en=1
//   reg_wr_ready : bank accepts on any rising edge with reg_wr_en & reg_wr_ready
// master = frame controller, slave = register bank.
// -----------------------------------------------------------------------------
interface uart_rx_frame_ctrl_if;

    logic        reg_wr_en;
    logic [7:0]  reg_addr;
    logic [15:0] reg_wr_data;
    logic        reg_wr_ready;

    modport master (
        output reg_wr_en,
        output reg_addr,
        output reg_wr_data,
        input  reg_wr_ready
    );

    modport slave (
        input  reg_wr_en,
        input  reg_addr,
        input  reg_wr_data,
        output reg_wr_ready
    );

endinterface

// File: rtl/uart_gap_timer.sv
// -----------------------------------------------------------------------------
// uart_gap_timer
// Counts clocks between received bytes while a frame is being collected.
//   clk_in    : system clock
//   rst_n     : asynchronous active-low reset
//   clear_i   : clears the counter (byte strobe, or no frame in progress)
//   enable_i  : counts when set and not cleared
//   timeout_o : high while the counter sits at TIMEOUT_CNT, unless a clear
//               arrives in the same cycle (the byte wins over the timeout)
// -----------------------------------------------------------------------------
module uart_gap_timer #(
    parameter logic [31:0] TIMEOUT_CNT = 32'd50_000
) (
    input  logic clk_in,
    input  logic rst_n,
    input  logic clear_i,
    input  logic enable_i,
    output logic timeout_o
);

    logic [31:0] gap_cnt_q, gap_cnt_d;

    // NOTE: every variable written in an always_comb gets a default first so
    // no path leaves it unassigned, which would infer a latch.
    always_comb begin
        gap_cnt_d = gap_cnt_q;
        if (clear_i) begin
            gap_cnt_d = '0;
        end else if (enable_i) begin
            gap_cnt_d = gap_cnt_q + 32'd1;
        end
    end

    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement or block ordering.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            gap_cnt_q <= '0;
        end else begin
            gap_cnt_q <= gap_cnt_d;
        end
    end

    assign timeout_o = enable_i && !clear_i && (gap_cnt_q == TIMEOUT_CNT);

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// -----------------------------------------------------------------------------
// uart_rx_frame_ctrl
// Hunts for SYNC_BYTE in the uart_rx_path byte stream, collects a 5-byte frame
// (SYNC, ADDR, DATA_H, DATA_L, CHK), verifies CHK == ADDR^DATA_H^DATA_L and
// issues one register write. Bad checksum, inter-byte timeout and bytes
// arriving while a write is pending are reported on err_valid/err_code.
//   clk_in, rst_n          : clock, asynchronous active-low reset
//   uart_rx_data/_done     : received byte and its one-cycle strobe
//   reg_bus (master)       : register write handshake (see interface)
//   err_valid / err_code   : one-cycle error strobe / last error code
//   frame_ok_cnt           : accepted writes, wraps at 16 bits
// -----------------------------------------------------------------------------
module uart_rx_frame_ctrl
    import uart_pkg::*;
#(
    parameter logic [7:0]  SYNC_BYTE   = DEFAULT_SYNC_BYTE,
    parameter logic [31:0] TIMEOUT_CNT = DEFAULT_TIMEOUT_CNT
) (
    input  logic                 clk_in,
    input  logic                 rst_n,
    input  logic [7:0]           uart_rx_data,
    input  logic                 uart_rx_done,
    uart_rx_frame_ctrl_if.master reg_bus,
    output logic                 err_valid,
    output logic [1:0]           err_code,
    output logic [15:0]          frame_ok_cnt
);

    state_e      state_q, state_d;
    logic [7:0]  hold_addr_q, hold_addr_d;
    logic [7:0]  hold_dh_q, hold_dh_d;
    logic [7:0]  hold_dl_q, hold_dl_d;
    logic [7:0]  wr_addr_q, wr_addr_d;
    logic [15:0] wr_data_q, wr_data_d;
    logic        err_valid_q, err_valid_d;
    err_code_e   err_code_q, err_code_d;
    logic [15:0] frame_ok_cnt_q, frame_ok_cnt_d;

    logic in_frame;
    logic timeout;

    // Only the ADDR..CHK positions are subject to the inter-byte timeout.
    assign in_frame = state_q inside {S_ADDR, S_DH, S_DL, S_CHK};

    uart_gap_timer #(
        .TIMEOUT_CNT (TIMEOUT_CNT)
    ) u_gap_timer (
        .clk_in    (clk_in),
        .rst_n     (rst_n),
        .clear_i   (uart_rx_done || !in_frame),
        .enable_i  (in_frame),
        .timeout_o (timeout)
    );

    always_comb begin
        state_d        = state_q;
        hold_addr_d    = hold_addr_q;
        hold_dh_d      = hold_dh_q;
        hold_dl_d      = hold_dl_q;
        wr_addr_d      = wr_addr_q;
        wr_data_d      = wr_data_q;
        err_valid_d    = 1'b0;
        err_code_d     = err_code_q;
        frame_ok_cnt_d = frame_ok_cnt_q;

        case (state_q)
            S_SYNC: begin
                // Non-sync bytes are dropped silently while hunting.
                if (uart_rx_done && (uart_rx_data == SYNC_BYTE)) begin
                    state_d = S_ADDR;
                end
            end
            S_ADDR: begin
                if (uart_rx_done) begin
                    hold_addr_d = uart_rx_data;
                    state_d     = S_DH;
                end
            end
            S_DH: begin
                if (uart_rx_done) begin
                    hold_dh_d = uart_rx_data;
                    state_d   = S_DL;
                end
            end
            S_DL: begin
                if (uart_rx_done) begin
                    hold_dl_d = uart_rx_data;
                    state_d   = S_CHK;
                end
            end
            S_CHK: begin
                if (uart_rx_done) begin
                    if (uart_rx_data == frame_chk(hold_addr_q, hold_dh_q, hold_dl_q)) begin
                        // Bus outputs only change here, so they are stable for
                        // the whole time reg_wr_en is high.
                        wr_addr_d = hold_addr_q;
                        wr_data_d = {hold_dh_q, hold_dl_q};
                        state_d   = S_WRITE;
                    end else begin
                        err_valid_d = 1'b1;
                        err_code_d  = ERR_CHK;
                        state_d     = S_SYNC;
                    end
                end
            end
            S_WRITE: begin
                if (reg_bus.reg_wr_ready) begin
                    state_d        = S_SYNC;
                    frame_ok_cnt_d = frame_ok_cnt_q + 16'd1;
                end
                // A byte during a pending write is lost; the write itself
                // proceeds untouched, even on the handshake cycle.
                if (uart_rx_done) begin
                    err_valid_d = 1'b1;
                    err_code_d  = ERR_OVR;
                end
            end
            default: begin
                state_d = S_SYNC;
            end
        endcase

        // The timer already masks the timeout when a byte strobe coincides.
        if (timeout) begin
            state_d     = S_SYNC;
            err_valid_d = 1'b1;
            err_code_d  = ERR_TMO;
        end
    end

    // NOTE: holding and output registers are reset along with the state so
    // every output reads zero immediately after reset, not just the FSM.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_SYNC;
            hold_addr_q    <= '0;
            hold_dh_q      <= '0;
            hold_dl_q      <= '0;
            wr_addr_q      <= '0;
            wr_data_q      <= '0;
            err_valid_q    <= 1'b0;
            err_code_q     <= ERR_NONE;
            frame_ok_cnt_q <= '0;
        end else begin
            state_q        <= state_d;
            hold_addr_q    <= hold_addr_d;
            hold_dh_q      <= hold_dh_d;
            hold_dl_q      <= hold_dl_d;
            wr_addr_q      <= wr_addr_d;
            wr_data_q      <= wr_data_d;
            err_valid_q    <= err_valid_d;
            err_code_q     <= err_code_d;
            frame_ok_cnt_q <= frame_ok_cnt_d;
        end
    end

    assign reg_bus.reg_wr_en   = (state_q == S_WRITE);
    assign reg_bus.reg_addr    = wr_addr_q;
    assign reg_bus.reg_wr_data = wr_data_q;
    assign err_valid           = err_valid_q;
    assign err_code            = err_code_q;
    assign frame_ok_cnt        = frame_ok_cnt_q;

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_frame_ctrl
// Scoreboard bench for uart_rx_frame_ctrl. The driver applies one cycle of
// stimulus at a time and feeds the same inputs to a byte-level reference
// model (collected-bytes queue, pending-write flag, edge arithmetic for the
// gap timeout). The model pushes expected writes/errors into queues; the
// monitor pops and compares whenever the DUT shows a handshake or error.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_rx_frame_ctrl;
    import uart_pkg::*;

    localparam logic [7:0] SYNC = 8'hAA;
    localparam int         T    = 100;

    logic        clk_in = 1'b0;
    logic        rst_n  = 1'b1;
    logic [7:0]  uart_rx_data = 8'h00;
    logic        uart_rx_done = 1'b0;
    logic        err_valid;
    logic [1:0]  err_code;
    logic [15:0] frame_ok_cnt;

    uart_rx_frame_ctrl_if reg_bus ();

    uart_rx_frame_ctrl #(
        .SYNC_BYTE   (SYNC),
        .TIMEOUT_CNT (32'(T))
    ) dut (
        .clk_in       (clk_in),
        .rst_n        (rst_n),
        .uart_rx_data (uart_rx_data),
        .uart_rx_done (uart_rx_done),
        .reg_bus      (reg_bus),
        .err_valid    (err_valid),
        .err_code     (err_code),
        .frame_ok_cnt (frame_ok_cnt)
    );

    always #5 clk_in = ~clk_in;

    // ---------------- scoreboard / reference model ----------------
    typedef struct {
        logic [7:0]  addr;
        logic [15:0] data;
        logic [15:0] cnt_before;
    } wr_exp_t;

    typedef struct {
        logic [1:0]  code;
        int unsigned edge_at;
    } err_exp_t;

    wr_exp_t     wr_q[$];
    err_exp_t    err_q[$];
    logic [7:0]  frame_buf[$];
    logic        m_pend = 1'b0;
    logic [7:0]  m_addr = 8'h00;
    logic [15:0] m_data = 16'h0000;
    logic [15:0] m_cnt = 16'h0000;
    logic [1:0]  m_last_err = 2'b00;
    int unsigned m_last_edge = 0;
    int unsigned edge_no = 0;
    int          rdy_mode = 1;   // 0: ready low, 1: ready high, 2: random
    int          n_vec = 0;
    int          n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h (edge %0d)", name, act, exp, edge_no);
        end
    endtask

    function automatic void push_err(input err_code_e c);
        err_q.push_back('{c, edge_no});
        m_last_err = c;
    endfunction

    function automatic void model_reset();
        wr_q.delete();
        err_q.delete();
        frame_buf.delete();
        m_pend     = 1'b0;
        m_addr     = 8'h00;
        m_data     = 16'h0000;
        m_cnt      = 16'h0000;
        m_last_err = 2'b00;
    endfunction

    // Applies the inputs seen at rising edge number edge_no.
    function automatic void model_step(input logic d, input logic [7:0] b, input logic r);
        if (m_pend) begin
            if (r) begin
                m_pend = 1'b0;
                m_cnt  = m_cnt + 16'd1;
            end
            if (d) push_err(ERR_OVR);
        end else if (d) begin
            if (frame_buf.size() != 0 || b == SYNC) frame_buf.push_back(b);
            m_last_edge = edge_no;
            if (frame_buf.size() == 5) begin
                if ((frame_buf[1] ^ frame_buf[2] ^ frame_buf[3]) == frame_buf[4]) begin
                    m_pend = 1'b1;
                    m_addr = frame_buf[1];
                    m_data = {frame_buf[2], frame_buf[3]};
                    wr_q.push_back('{m_addr, m_data, m_cnt});
                end else begin
                    push_err(ERR_CHK);
                end
                frame_buf.delete();
            end
        end else if (frame_buf.size() != 0 && (edge_no - m_last_edge) == 32'(T + 1)) begin
            push_err(ERR_TMO);
            frame_buf.delete();
        end
    endfunction

    // ---------------- monitor ----------------
    always @(negedge clk_in) begin
        if (rst_n) begin
            check("wr_en", 32'(reg_bus.reg_wr_en), 32'(m_pend));
            if (m_pend) begin
                check("wr_addr_stable", 32'(reg_bus.reg_addr), 32'(m_addr));
                check("wr_data_stable", 32'(reg_bus.reg_wr_data), 32'(m_data));
            end
            check("err_code_hold", 32'(err_code), 32'(m_last_err));
            if (reg_bus.reg_wr_en && reg_bus.reg_wr_ready) begin
                check("wr_expected", 32'(wr_q.size() != 0), 32'd1);
                if (wr_q.size() != 0) begin
                    wr_exp_t w;
                    w = wr_q.pop_front();
                    check("wr_addr", 32'(reg_bus.reg_addr), 32'(w.addr));
                    check("wr_data", 32'(reg_bus.reg_wr_data), 32'(w.data));
                    check("ok_cnt_pre", 32'(frame_ok_cnt), 32'(w.cnt_before));
                end
            end
            if (err_valid) begin
                check("err_expected", 32'(err_q.size() != 0), 32'd1);
                if (err_q.size() != 0) begin
                    err_exp_t e;
                    e = err_q.pop_front();
                    check("err_code", 32'(err_code), 32'(e.code));
                    check("err_edge", 32'(edge_no), 32'(e.edge_at));
                end
            end
        end
    end

    // ---------------- driver ----------------
    // NOTE: inputs are driven with blocking assignments 1 ns after the edge so
    // the DUT and the model both see them settled at the next rising edge.
    task automatic cyc(input logic d, input logic [7:0] b);
        logic r;
        case (rdy_mode)
            0:       r = 1'b0;
            1:       r = 1'b1;
            default: r = ($urandom_range(0, 3) != 0);
        endcase
        uart_rx_done         = d;
        uart_rx_data         = d ? b : 8'($urandom);
        reg_bus.reg_wr_ready = r;
        @(posedge clk_in);
        edge_no++;
        model_step(d, b, r);
        #1;
        uart_rx_done = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, 8'h00);
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        cyc(1'b1, b);
        idle(gap);
    endtask

    task automatic send_frame(input logic [7:0] a, input logic [7:0] dh,
                              input logic [7:0] dl, input logic [7:0] chk, input int gap);
        send(SYNC, gap);
        send(a, gap);
        send(dh, gap);
        send(dl, gap);
        send(chk, gap);
    endtask

    function automatic int rand_gap();
        int r;
        r = int'($urandom_range(0, 39));
        if (r == 0) return T;       // exactly at the limit: byte wins
        if (r == 1) return T + 1;   // one past: timeout
        return int'($urandom_range(0, 2));
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_wr_en"},  32'(reg_bus.reg_wr_en), 32'd0);
        check({tag, "_addr"},   32'(reg_bus.reg_addr), 32'd0);
        check({tag, "_data"},   32'(reg_bus.reg_wr_data), 32'd0);
        check({tag, "_errv"},   32'(err_valid), 32'd0);
        check({tag, "_errc"},   32'(err_code), 32'd0);
        check({tag, "_okcnt"},  32'(frame_ok_cnt), 32'd0);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        logic [7:0] a, dh, dl, chk;
        reg_bus.reg_wr_ready = 1'b0;
        #2 rst_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clk_in);
        check_all_zero("reset");
        @(posedge clk_in);
        #1 rst_n = 1'b1;

        // Valid write with ready held high.
        rdy_mode = 1;
        send_frame(8'h12, 8'h34, 8'h56, 8'h70, 0);
        idle(3);
        check("ok_cnt_first", 32'(frame_ok_cnt), 32'd1);

        // Checksum error, then a good frame.
        send_frame(8'h12, 8'h34, 8'h56, 8'h71, 0);
        idle(2);
        send_frame(8'h21, 8'h43, 8'h65, 8'h21 ^ 8'h43 ^ 8'h65, 1);
        idle(3);

        // Timeout after ADDR; trailing bytes dropped while hunting.
        send(SYNC, 0);
        send(8'h12, T + 3);
        send(8'h34, 0);
        send(8'h56, 0);
        send_frame(8'h0F, 8'hF0, 8'h5A, 8'h0F ^ 8'hF0 ^ 8'h5A, 0);
        idle(3);

        // Byte arriving exactly at the timeout limit still counts.
        send(SYNC, T);
        send(8'h44, T);
        send(8'h55, 0);
        send(8'h66, 0);
        send(8'h44 ^ 8'h55 ^ 8'h66, 0);
        idle(3);

        // Backpressure with one overrun byte during the stall.
        rdy_mode = 0;
        send_frame(8'h9C, 8'hDE, 8'hAD, 8'h9C ^ 8'hDE ^ 8'hAD, 0);
        idle(5);
        send(8'h55, 14);
        rdy_mode = 1;
        idle(3);

        // Overrun on the same edge as the handshake.
        rdy_mode = 0;
        send_frame(8'h01, 8'h02, 8'h03, 8'h00, 0);
        idle(3);
        rdy_mode = 1;
        send(8'h77, 3);

        // Hunt past junk, SYNC value used as payload.
        send(8'h00, 0);
        send(8'hFF, 0);
        send_frame(8'hAA, 8'hAA, 8'h13, 8'hAA ^ 8'hAA ^ 8'h13, 0);
        idle(3);

        // Reset after DH aborts the frame; the tail is then ignored.
        send(SYNC, 0);
        send(8'h12, 0);
        send(8'h34, 0);
        rst_n = 1'b0;
        model_reset();
        @(negedge clk_in);
        check_all_zero("midrst");
        @(posedge clk_in);
        #1 rst_n = 1'b1;
        send(8'h56, 0);
        send(8'h70, 2);
        send_frame(8'h12, 8'h34, 8'h56, 8'h70, 0);
        idle(3);
        check("ok_cnt_after_rst", 32'(frame_ok_cnt), 32'd1);

        // Randomized traffic with random ready.
        rdy_mode = 2;
        for (int i = 0; i < 150; i++) begin
            case ($urandom_range(0, 5))
                0: send(8'($urandom), rand_gap());
                1: begin
                    a   = 8'($urandom);
                    dh  = 8'($urandom);
                    dl  = 8'($urandom);
                    chk = (a ^ dh ^ dl) ^ 8'($urandom_range(1, 255));
                    send_frame(a, dh, dl, chk, int'($urandom_range(0, 1)));
                end
                default: begin
                    a  = ($urandom_range(0, 4) == 0) ? SYNC : 8'($urandom);
                    dh = ($urandom_range(0, 4) == 0) ? SYNC : 8'($urandom);
                    dl = 8'($urandom);
                    send(SYNC, rand_gap());
                    send(a, rand_gap());
                    send(dh, rand_gap());
                    send(dl, rand_gap());
                    send(a ^ dh ^ dl, int'($urandom_range(0, 4)));
                end
            endcase
        end
        rdy_mode = 1;
        idle(T + 5);

        // Counter wrap from a preloaded 16'hFFFF.
        force dut.frame_ok_cnt_q = 16'hFFFF;
        idle(1);
        release dut.frame_ok_cnt_q;
        m_cnt = 16'hFFFF;
        idle(1);
        send_frame(8'h5A, 8'hC3, 8'h3C, 8'h5A ^ 8'hC3 ^ 8'h3C, 0);
        idle(3);
        check("ok_cnt_wrap", 32'(frame_ok_cnt), 32'h0000);

        // Drain and final consistency.
        idle(5);
        check("wr_q_drained", 32'(wr_q.size()), 32'd0);
        check("err_q_drained", 32'(err_q.size()), 32'd0);
        check("ok_cnt_final", 32'(frame_ok_cnt), 32'(m_cnt));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
